// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter for four requesters sharing one WIDTH-bit register bank.
// A grant lasts one cycle (WRITE); the granted slice of d_bus is loaded on the following edge.
module dff_bank_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d_bus,
  output logic [3:0]         grant,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar,
  output logic               busy,
  output logic [1:0]         last_id,
  output logic [7:0]         wr_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_grant;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_last_id;
  logic [7:0]       r_wr_count;
  logic [1:0]       w_win_id;
  logic             w_found;
  logic [WIDTH-1:0] w_sel_data;

  // Scan last_id+1 .. last_id+4 (mod 4); the first index with req set wins.
  always_comb begin
    w_win_id = r_last_id;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = r_last_id + 2'(k);
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_win_id = idx;
      end
    end
  end

  // The winner is latched into last_id, so it also selects the write data.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_last_id == 2'(i)) w_sel_data = d_bus[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_q        <= '0;
      r_last_id  <= 2'd3;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant   <= 4'b0001 << w_win_id;
            r_last_id <= w_win_id;
          end else begin
            r_grant <= '0;
          end
        end
        WRITE: begin
          r_q        <= w_sel_data;
          r_grant    <= '0;
          r_wr_count <= r_wr_count + 8'd1;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant    = r_grant;
  assign q        = r_q;
  assign qbar     = ~r_q;
  assign busy     = (r_state == WRITE);
  assign last_id  = r_last_id;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, single write, round-robin order,
// wrap-around scan, drop during WRITE, reset mid-write and wr_count wrap.
module tb_dff_bank_arbiter;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] d_bus;
  logic [3:0]         grant;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qbar;
  logic               busy;
  logic [1:0]         last_id;
  logic [7:0]         wr_count;

  int unsigned n_tests;
  int unsigned n_fail;

  dff_bank_arbiter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .d_bus    (d_bus),
    .grant    (grant),
    .q        (q),
    .qbar     (qbar),
    .busy     (busy),
    .last_id  (last_id),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    d_bus   = '0;

    // Reset then idle
    step();
    step();
    check("rst_q",       32'(q),        32'h00);
    check("rst_qbar",    32'(qbar),     32'hFF);
    check("rst_grant",   32'(grant),    32'h0);
    check("rst_busy",    32'(busy),     32'h0);
    check("rst_wrcnt",   32'(wr_count), 32'h0);
    check("rst_last_id", 32'(last_id),  32'h3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_q",     32'(q),        32'h00);
      check("idle_qbar",  32'(qbar),     32'hFF);
      check("idle_grant", 32'(grant),    32'h0);
      check("idle_wrcnt", 32'(wr_count), 32'h0);
    end

    // Single requester 2 with 0xA5
    req   = 4'b0100;
    d_bus = {8'h00, 8'hA5, 8'h00, 8'h00};
    step();
    check("single_grant", 32'(grant),   32'h4);
    check("single_busy",  32'(busy),    32'h1);
    check("single_last",  32'(last_id), 32'h2);
    req = 4'b0000;
    step();
    check("single_q",     32'(q),        32'hA5);
    check("single_qbar",  32'(qbar),     32'h5A);
    check("single_wrcnt", 32'(wr_count), 32'h1);
    check("single_grant0",32'(grant),    32'h0);
    check("single_busy0", 32'(busy),     32'h0);

    // Fairness from reset: all four requesting, expect 0,1,2,3,0,1,2,3
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b1111;
    d_bus = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int w = 0; w < 8; w++) begin
      step();
      check("rr_grant", 32'(grant), 32'h1 << (w % 4));
      check("rr_busy",  32'(busy),  32'h1);
      step();
      check("rr_q",     32'(q),     32'h10 + 32'(w % 4));
      check("rr_grant0",32'(grant), 32'h0);
    end
    check("rr_wrcnt", 32'(wr_count), 32'h8);

    // Wrap-around scan: bring last_id to 1, then only requester 0
    req = 4'b0010;
    step();
    check("wrap_pre_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    step();
    check("wrap_pre_last", 32'(last_id), 32'h1);
    req = 4'b0001;
    step();
    check("wrap_grant", 32'(grant),   32'h1);
    check("wrap_last",  32'(last_id), 32'h0);
    req = 4'b0000;
    step();
    check("wrap_q", 32'(q), 32'h10);

    // Requester 3 drops req during WRITE; write still completes with 0x3C
    req = 4'b1000;
    step();
    check("drop_grant", 32'(grant), 32'h8);
    req   = 4'b0000;
    d_bus = {8'h3C, 8'h12, 8'h11, 8'h10};
    step();
    check("drop_q",     32'(q),        32'h3C);
    check("drop_wrcnt", 32'(wr_count), 32'd11);
    check("drop_busy",  32'(busy),     32'h0);

    // Reset asserted in the WRITE cycle aborts the write
    req = 4'b0001;
    step();
    check("abort_grant", 32'(grant), 32'h1);
    rst_n = 1'b0;
    req   = 4'b0000;
    d_bus = '1;
    step();
    check("abort_q",     32'(q),        32'h00);
    check("abort_qbar",  32'(qbar),     32'hFF);
    check("abort_grant0",32'(grant),    32'h0);
    check("abort_wrcnt", 32'(wr_count), 32'h0);
    check("abort_last",  32'(last_id),  32'h3);
    check("abort_busy",  32'(busy),     32'h0);
    rst_n = 1'b1;

    // wr_count wraps 255 -> 0
    req   = 4'b0001;
    d_bus = {8'h00, 8'h00, 8'h00, 8'h77};
    for (int w = 0; w < 255; w++) begin
      step();
      step();
    end
    check("cnt_255", 32'(wr_count), 32'd255);
    step();
    check("cnt_wrap_grant", 32'(grant), 32'h1);
    step();
    check("cnt_wrap",   32'(wr_count), 32'd0);
    check("cnt_wrap_q", 32'(q),        32'h77);
    req = 4'b0000;
    step();
    check("cnt_idle_grant", 32'(grant), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
